// File: rtl/puf_proto_pkg.sv
// Shared definitions for the PUF challenge/response UART protocol.
// Both the host-side initiator and the responder controller use this package.
package puf_proto_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_TX,
    RECV,
    DONE
  } puf_state_t;

  localparam int RESP_BYTES_DEF     = 32;
  localparam int TIMEOUT_CYCLES_DEF = 1_000_000;
  localparam int RESP_W_DEF         = 8 * RESP_BYTES_DEF;

  // Width in bits of a response made of n_bytes bytes.
  function automatic int resp_width(input int n_bytes);
    return 8 * n_bytes;
  endfunction

endpackage

// File: rtl/puf_uart_initiator_if.sv
// Challenge/response bundle between the initiator and the UART TX/RX
// plus the request side. master = initiator, slave = its environment.
interface puf_uart_initiator_if #(
  parameter int RESP_BYTES = puf_proto_pkg::RESP_BYTES_DEF
);
  localparam int RESP_W = puf_proto_pkg::resp_width(RESP_BYTES);

  logic              start;
  logic [7:0]        challenge;
  logic [7:0]        tx_byte;
  logic              tx_DV;
  logic              tx_done;
  logic [7:0]        rx_byte;
  logic              rx_DV;
  logic [RESP_W-1:0] response;
  logic              response_valid;
  logic              busy;
  logic              timeout;

  modport master (
    input  start, challenge, tx_done, rx_byte, rx_DV,
    output tx_byte, tx_DV, response, response_valid, busy, timeout
  );

  modport slave (
    output start, challenge, tx_done, rx_byte, rx_DV,
    input  tx_byte, tx_DV, response, response_valid, busy, timeout
  );

endinterface

// File: rtl/puf_timeout_ctr.sv
// Inactivity timer: down-counter loaded with CYCLES-1, counts while enabled,
// saturates at zero. tc is high once CYCLES enabled cycles have elapsed
// since the last load, so the owner can act on that same cycle.
module puf_timeout_ctr #(
  parameter int CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset_n,
  input  logic load,
  input  logic en,
  output logic tc
);
  localparam int            CW       = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LOAD_VAL = CW'(CYCLES - 1);

  logic [CW-1:0] cnt;

  // Reload has priority over counting; the counter never wraps below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= LOAD_VAL;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign tc = (cnt == '0);

endmodule

// File: rtl/puf_uart_initiator.sv
// Host-side PUF initiator: sends one challenge byte, then shifts RESP_BYTES
// received bytes into the response word (first byte ends up in the MSBs).
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  IDLE    | waiting for start; only state where start is accepted
//  SEND    | issue the one-cycle transmit strobe with the challenge
//  WAIT_TX | wait for transmitter completion; no timeout here
//  RECV    | collect response bytes, inactivity timer running
//  DONE    | one-cycle response_valid, then back to IDLE
module puf_uart_initiator
  import puf_proto_pkg::*;
#(
  parameter int RESP_BYTES     = RESP_BYTES_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input logic                  clk,
  input logic                  reset_n,
  puf_uart_initiator_if.master bus
);
  localparam int                RESP_W   = resp_width(RESP_BYTES);
  localparam int                BCNT_W   = $clog2(RESP_BYTES + 1);
  localparam logic [BCNT_W-1:0] LAST_IDX = BCNT_W'(RESP_BYTES - 1);

  puf_state_t        state, state_d;
  logic [7:0]        chal_q;
  logic [7:0]        tx_byte_q;
  logic              tx_dv_q;
  logic [RESP_W-1:0] resp_q;
  logic              resp_valid_q;
  logic              timeout_q;
  logic [BCNT_W-1:0] byte_cnt;

  logic accept_start;
  logic accept_byte;
  logic cnt_clr;
  logic tmo_fire;
  logic tmr_load;
  logic tmr_en;
  logic tmr_tc;

  puf_timeout_ctr #(
    .CYCLES (TIMEOUT_CYCLES)
  ) u_tmr (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .en      (tmr_en),
    .tc      (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state and datapath controls; a byte arriving on the terminal-count
  // cycle is taken and reloads the timer instead of raising timeout.
  always_comb begin
    state_d      = state;
    accept_start = 1'b0;
    accept_byte  = 1'b0;
    cnt_clr      = 1'b0;
    tmo_fire     = 1'b0;
    tmr_load     = 1'b0;
    tmr_en       = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          accept_start = 1'b1;
          state_d      = SEND;
        end
      end
      SEND: begin
        state_d = WAIT_TX;
      end
      WAIT_TX: begin
        if (bus.tx_done) begin
          cnt_clr  = 1'b1;
          tmr_load = 1'b1;
          state_d  = RECV;
        end
      end
      RECV: begin
        tmr_en = 1'b1;
        if (bus.rx_DV) begin
          accept_byte = 1'b1;
          tmr_load    = 1'b1;
          if (byte_cnt == LAST_IDX) begin
            state_d = DONE;
          end
        end else if (tmr_tc) begin
          tmo_fire = 1'b1;
          state_d  = IDLE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Challenge capture and the registered transmit strobe/byte.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      chal_q    <= '0;
      tx_byte_q <= '0;
      tx_dv_q   <= 1'b0;
    end else begin
      tx_dv_q <= (state == SEND);
      if (accept_start) begin
        chal_q <= bus.challenge;
      end
      if (state == SEND) begin
        tx_byte_q <= chal_q;
      end
    end
  end

  // Response shift register and byte counter; only RECV touches them.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_q   <= '0;
      byte_cnt <= '0;
    end else begin
      if (cnt_clr) begin
        byte_cnt <= '0;
      end else if (accept_byte) begin
        byte_cnt <= byte_cnt + BCNT_W'(1);
      end
      if (accept_byte) begin
        resp_q <= (resp_q << 8) | RESP_W'(bus.rx_byte);
      end
    end
  end

  // Completion strobe and sticky timeout flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      resp_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      resp_valid_q <= (state_d == DONE);
      if (accept_start) begin
        timeout_q <= 1'b0;
      end else if (tmo_fire) begin
        timeout_q <= 1'b1;
      end
    end
  end

  assign bus.tx_byte        = tx_byte_q;
  assign bus.tx_DV          = tx_dv_q;
  assign bus.response       = resp_q;
  assign bus.response_valid = resp_valid_q;
  assign bus.busy           = (state != IDLE);
  assign bus.timeout        = timeout_q;

endmodule

// File: tb/tb_puf_uart_initiator.sv
// Bench for puf_uart_initiator: a full-size instance (32 bytes) and a small
// instance (4 bytes, 50-cycle timeout). Expected responses go into per-
// instance queues when stimulus is driven and are popped on response_valid.
module tb_puf_uart_initiator;

  logic clk = 1'b0;
  logic reset_n;

  always #50 clk = ~clk;

  puf_uart_initiator_if #(.RESP_BYTES(32)) a ();
  puf_uart_initiator_if #(.RESP_BYTES(4))  b ();

  puf_uart_initiator #(
    .RESP_BYTES     (32),
    .TIMEOUT_CYCLES (1_000_000)
  ) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (a.master)
  );

  puf_uart_initiator #(
    .RESP_BYTES     (4),
    .TIMEOUT_CYCLES (50)
  ) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (b.master)
  );

  int n_cmp     = 0;
  int n_bad     = 0;
  int n_valid_a = 0;
  int n_valid_b = 0;
  int n_txdv_a  = 0;

  logic [255:0] exp_a[$];
  logic [31:0]  exp_b[$];
  logic [255:0] e;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard side: count strobes and compare responses against the queues.
  always @(negedge clk) begin
    if (a.tx_DV) n_txdv_a++;
    if (a.response_valid) begin
      n_valid_a++;
      chk("a_valid_expected", 256'(exp_a.size() != 0), 256'd1);
      if (exp_a.size() != 0) chk("a_response", a.response, exp_a.pop_front());
    end
    if (b.response_valid) begin
      n_valid_b++;
      chk("b_valid_expected", 256'(exp_b.size() != 0), 256'd1);
      if (exp_b.size() != 0) chk("b_response", 256'(b.response), 256'(exp_b.pop_front()));
    end
  end

  initial begin
    reset_n     = 1'b0;
    a.start     = 1'b0;
    a.challenge = 8'h00;
    a.tx_done   = 1'b0;
    a.rx_byte   = 8'h00;
    a.rx_DV     = 1'b0;
    b.start     = 1'b0;
    b.challenge = 8'h00;
    b.tx_done   = 1'b0;
    b.rx_byte   = 8'h00;
    b.rx_DV     = 1'b0;
    tick(2);

    chk("rst_busy",     256'(a.busy), 256'd0);
    chk("rst_tx_dv",    256'(a.tx_DV), 256'd0);
    chk("rst_tx_byte",  256'(a.tx_byte), 256'd0);
    chk("rst_response", a.response, 256'd0);
    chk("rst_valid",    256'(a.response_valid), 256'd0);
    chk("rst_timeout",  256'(a.timeout), 256'd0);
    chk("rst_b_busy",   256'(b.busy), 256'd0);

    reset_n = 1'b1;
    tick();

    // tx_done in IDLE does nothing
    a.tx_done = 1'b1;
    tick();
    a.tx_done = 1'b0;
    chk("idle_tx_done_busy", 256'(a.busy), 256'd0);

    // start with A5, stale rx bytes held through IDLE/SEND/WAIT_TX
    a.challenge = 8'hA5;
    a.start     = 1'b1;
    a.rx_byte   = 8'hEE;
    a.rx_DV     = 1'b1;
    tick();
    a.start = 1'b0;
    chk("start_busy",    256'(a.busy), 256'd1);
    chk("start_tx_dv_0", 256'(a.tx_DV), 256'd0);
    tick();
    chk("send_tx_dv",    256'(a.tx_DV), 256'd1);
    chk("send_tx_byte",  256'(a.tx_byte), 256'hA5);
    tick();
    chk("send_tx_dv_end", 256'(a.tx_DV), 256'd0);
    tick();
    a.rx_DV = 1'b0;

    e = '0;
    for (int i = 0; i < 32; i++) e = {e[247:0], 8'(i)};
    exp_a.push_back(e);

    a.tx_done = 1'b1;
    tick();
    a.tx_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a.rx_byte = 8'(i);
      a.rx_DV   = 1'b1;
      tick();
      a.rx_DV = 1'b0;
      if (i == 31) begin
        chk("a_valid_latency", 256'(a.response_valid), 256'd1);
        chk("a_done_busy",     256'(a.busy), 256'd1);
      end
      if (i == 5) begin
        a.challenge = 8'h3C;
        a.start     = 1'b1;
      end
      tick();
      a.start = 1'b0;
    end
    tick(2);
    chk("a_valid_count_1",  256'(n_valid_a), 256'd1);
    chk("a_idle_busy",      256'(a.busy), 256'd0);
    chk("a_valid_dropped",  256'(a.response_valid), 256'd0);
    chk("a_response_hold",  a.response, e);
    chk("a_tx_dv_count_1",  256'(n_txdv_a), 256'd1);
    chk("a_queue_empty_1",  256'(exp_a.size()), 256'd0);

    // reset in the middle of RECV
    a.challenge = 8'h11;
    a.start     = 1'b1;
    tick();
    a.start = 1'b0;
    tick(2);
    a.tx_done = 1'b1;
    tick();
    a.tx_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a.rx_byte = 8'h80 + 8'(i);
      a.rx_DV   = 1'b1;
      tick();
      a.rx_DV = 1'b0;
      tick();
    end
    chk("pre_rst_busy", 256'(a.busy), 256'd1);
    #20;
    reset_n = 1'b0;
    #5;
    chk("async_rst_busy",     256'(a.busy), 256'd0);
    chk("async_rst_tx_byte",  256'(a.tx_byte), 256'd0);
    chk("async_rst_response", a.response, 256'd0);
    chk("async_rst_timeout",  256'(a.timeout), 256'd0);
    tick(2);
    reset_n = 1'b1;
    tick();

    e = '0;
    for (int i = 0; i < 32; i++) e = {e[247:0], 8'hC0 ^ 8'(i)};
    exp_a.push_back(e);
    a.challenge = 8'h22;
    a.start     = 1'b1;
    tick();
    a.start = 1'b0;
    tick();
    chk("post_rst_tx_byte", 256'(a.tx_byte), 256'h22);
    tick();
    a.tx_done = 1'b1;
    tick();
    a.tx_done = 1'b0;
    for (int i = 0; i < 32; i++) begin
      a.rx_byte = 8'hC0 ^ 8'(i);
      a.rx_DV   = 1'b1;
      tick();
      a.rx_DV = 1'b0;
    end
    tick(2);
    chk("a_valid_count_2", 256'(n_valid_a), 256'd2);
    chk("a_response_2",    a.response, e);
    chk("a_tx_dv_count_3", 256'(n_txdv_a), 256'd3);
    chk("a_queue_empty_2", 256'(exp_a.size()), 256'd0);

    // small instance: 2 bytes then silence -> timeout after 50 cycles
    b.challenge = 8'h5A;
    b.start     = 1'b1;
    tick();
    b.start = 1'b0;
    tick();
    chk("b_tx_byte", 256'(b.tx_byte), 256'h5A);
    tick();
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
    b.rx_byte = 8'hAB;
    b.rx_DV   = 1'b1;
    tick();
    b.rx_DV = 1'b0;
    tick();
    b.rx_byte = 8'hCD;
    b.rx_DV   = 1'b1;
    tick();
    b.rx_DV = 1'b0;
    tick(49);
    chk("b_tmo_49_flag", 256'(b.timeout), 256'd0);
    chk("b_tmo_49_busy", 256'(b.busy), 256'd1);
    tick();
    chk("b_tmo_50_flag",  256'(b.timeout), 256'd1);
    chk("b_tmo_50_busy",  256'(b.busy), 256'd0);
    chk("b_tmo_partial",  256'(b.response), 256'h0000ABCD);
    chk("b_tmo_no_valid", 256'(n_valid_b), 256'd0);
    tick(3);
    chk("b_tmo_sticky", 256'(b.timeout), 256'd1);

    // byte on the terminal-count cycle wins, twice in a row
    exp_b.push_back(32'h01020304);
    b.challenge = 8'h66;
    b.start     = 1'b1;
    tick();
    b.start = 1'b0;
    chk("b_start_clears_tmo", 256'(b.timeout), 256'd0);
    tick(2);
    b.tx_done = 1'b1;
    tick();
    b.tx_done = 1'b0;
    tick(49);
    b.rx_byte = 8'h01;
    b.rx_DV   = 1'b1;
    tick();
    b.rx_DV = 1'b0;
    chk("b_tc_byte1_tmo",  256'(b.timeout), 256'd0);
    chk("b_tc_byte1_busy", 256'(b.busy), 256'd1);
    tick(49);
    b.rx_byte = 8'h02;
    b.rx_DV   = 1'b1;
    tick();
    b.rx_DV = 1'b0;
    chk("b_tc_byte2_tmo",  256'(b.timeout), 256'd0);
    chk("b_tc_byte2_busy", 256'(b.busy), 256'd1);
    b.rx_byte = 8'h03;
    b.rx_DV   = 1'b1;
    tick();
    b.rx_DV = 1'b0;
    tick();
    b.rx_byte = 8'h04;
    b.rx_DV   = 1'b1;
    tick();
    b.rx_DV = 1'b0;
    chk("b_valid_latency", 256'(b.response_valid), 256'd1);
    tick(2);
    chk("b_valid_count", 256'(n_valid_b), 256'd1);
    chk("b_queue_empty", 256'(exp_b.size()), 256'd0);
    chk("b_final_tmo",   256'(b.timeout), 256'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
